// File: rtl/multdiv_pkg.sv
// Shared constants and state types for the multdiv unit (multiplier and divider).
package multdiv_pkg;

  localparam int DIV_WIDTH  = 32;
  localparam int DIV_ITERS  = 32;
  localparam int MULT_WIDTH = 32;
  localparam int MULT_ITERS = 32;

  localparam logic [DIV_WIDTH-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  typedef enum logic [1:0] {
    MULT_IDLE = 2'd0,
    MULT_RUN  = 2'd1,
    MULT_DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/div_iter.sv
// One restoring shift-subtract step: shifts {rem, quo} left, trial-subtracts the divisor.
// Purely combinational; the caller registers rem_o/quo_o each cycle.
module div_iter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // One extra guard bit keeps the trial sign unambiguous for any partial remainder.
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign trial   = shifted - {2'b00, divisor_i};

  always_comb begin
    rem_o = shifted[WIDTH:0];
    quo_o = {quo_i[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH+1]) begin
      rem_o    = trial[WIDTH:0];
      quo_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/signed_divider.sv
// Sequential signed divider: 32 restoring iterations on magnitudes, then sign fix-up.
// Start is accepted in any state and aborts any operation in flight.
module signed_divider
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             exception,
  output logic             ready
);

  localparam int CW = $clog2(DIV_ITERS);
  localparam logic [CW-1:0]    LAST_ITER = CW'(DIV_ITERS - 1);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] divisor_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             div0_q;
  logic             ovf_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             exception_q;
  logic             ready_q;

  logic [WIDTH-1:0] abs_a_d;
  logic [WIDTH-1:0] abs_b_d;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] q_fix_d;
  logic [WIDTH-1:0] r_fix_d;

  // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
  assign abs_a_d = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b_d = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  assign q_fix_d = q_neg_q ? -quo_q : quo_q;
  assign r_fix_d = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  div_iter #(.WIDTH(WIDTH)) u_iter (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (rem_d),
    .quo_o     (quo_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      exception_q <= 1'b0;
      ready_q     <= 1'b0;
    end else if (ctrl_div) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= abs_a_d;
      divisor_q <= abs_b_d;
      q_neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_neg_q   <= data_operandA[WIDTH-1];
      div0_q    <= (data_operandB == '0);
      ovf_q     <= (data_operandA == MOST_NEG) && (data_operandB == '1);
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ready_q <= 1'b0;
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_q <= FIX;
        end
        FIX: begin
          if (div0_q || ovf_q) begin
            quotient_q  <= '0;
            remainder_q <= '0;
            exception_q <= 1'b1;
          end else begin
            quotient_q  <= q_fix_d;
            remainder_q <= r_fix_d;
            exception_q <= 1'b0;
          end
          ready_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign exception = exception_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_signed_divider.sv
// Scoreboard bench for signed_divider: directed test-plan cases plus random back-to-back ops.
module tb_signed_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_div = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        exception;
  logic        ready;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  signed_divider #(.WIDTH(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_div      (ctrl_div),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .quotient      (quotient),
    .remainder     (remainder),
    .exception     (exception),
    .ready         (ready)
  );

  always #5 clock = ~clock;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t m;
    logic signed [31:0] sa;
    logic signed [31:0] sd;
    sa = a;
    sd = b;
    if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
      m.q = '0; m.r = '0; m.e = 1'b1;
    end else begin
      m.q = sa / sd; m.r = sa % sd; m.e = 1'b0;
    end
    return m;
  endfunction

  // Drive a start for the coming edge, record its expectation, drop ctrl_div after that edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input logic e);
    exp_t x;
    data_operandA = a;
    data_operandB = b;
    ctrl_div = 1'b1;
    x.q = q; x.r = r; x.e = e;
    sbq.push_back(x);
    @(negedge clock);
    ctrl_div = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r, input logic e);
    @(negedge clock);
    launch(a, b, q, r, e);
  endtask

  // Returns cycles since the start edge at which ready is seen, or -1 on timeout.
  task automatic wait_ready(input int budget, output int lat, output logic [31:0] q,
                            output logic [31:0] r, output logic e);
    lat = -1; q = 'x; r = 'x; e = 1'bx;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clock);
      if (ready === 1'b1) begin
        lat = n; q = quotient; r = remainder; e = exception;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient: got %h want 0", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL reset_remainder: got %h want 0", remainder); end
    checks++; if (exception !== 1'b0) begin errors++; $display("FAIL reset_exception: got %b want 0", exception); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int lat; logic [31:0] q, r; logic e; exp_t x;
    do_start(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    wait_ready(40, lat, q, r, e);
    x = sbq.pop_front();
    checks++; if (lat != 33) begin errors++; $display("FAIL basic_latency: got %0d want 33", lat); end
    checks++; if (q !== x.q) begin errors++; $display("FAIL basic_quotient: got %h want %h", q, x.q); end
    checks++; if (r !== x.r) begin errors++; $display("FAIL basic_remainder: got %h want %h", r, x.r); end
    checks++; if (e !== x.e) begin errors++; $display("FAIL basic_exception: got %b want %b", e, x.e); end
    @(negedge clock);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL basic_ready_pulse: got %b want 0", ready); end
  endtask

  task automatic test_signs;
    logic [31:0] ta [3] = '{32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C};
    logic [31:0] tb [3] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] tq [3] = '{32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14};
    logic [31:0] tr [3] = '{32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFE};
    int lat; logic [31:0] q, r; logic e; exp_t x;
    for (int i = 0; i < 3; i++) begin
      do_start(ta[i], tb[i], tq[i], tr[i], 1'b0);
      wait_ready(40, lat, q, r, e);
      x = sbq.pop_front();
      checks++; if (lat != 33) begin errors++; $display("FAIL signs_latency[%0d]: got %0d want 33", i, lat); end
      checks++; if (q !== x.q) begin errors++; $display("FAIL signs_quotient[%0d]: got %h want %h", i, q, x.q); end
      checks++; if (r !== x.r) begin errors++; $display("FAIL signs_remainder[%0d]: got %h want %h", i, r, x.r); end
      checks++; if (e !== x.e) begin errors++; $display("FAIL signs_exception[%0d]: got %b want %b", i, e, x.e); end
    end
  endtask

  task automatic test_exceptions;
    logic [31:0] ta [4] = '{32'd5, 32'd9, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] tb [4] = '{32'd0, 32'd3, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] tq [4] = '{32'd0, 32'd3, 32'd0, 32'h8000_0000};
    logic        te [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int lat; logic [31:0] q, r; logic e; exp_t x;
    for (int i = 0; i < 4; i++) begin
      do_start(ta[i], tb[i], tq[i], 32'd0, te[i]);
      wait_ready(40, lat, q, r, e);
      x = sbq.pop_front();
      checks++; if (lat != 33) begin errors++; $display("FAIL exc_latency[%0d]: got %0d want 33", i, lat); end
      checks++; if (q !== x.q) begin errors++; $display("FAIL exc_quotient[%0d]: got %h want %h", i, q, x.q); end
      checks++; if (r !== x.r) begin errors++; $display("FAIL exc_remainder[%0d]: got %h want %h", i, r, x.r); end
      checks++; if (e !== x.e) begin errors++; $display("FAIL exc_exception[%0d]: got %b want %b", i, e, x.e); end
    end
  endtask

  task automatic test_hold;
    int lat; logic [31:0] q, r; logic e; exp_t x;
    do_start(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
    wait_ready(40, lat, q, r, e);
    x = sbq.pop_front();
    checks++; if (q !== x.q) begin errors++; $display("FAIL hold_first_quotient: got %h want %h", q, x.q); end
    do_start(32'd7, 32'd2, 32'd3, 32'd1, 1'b0);
    repeat (5) @(negedge clock);
    checks++; if (quotient !== 32'd100) begin errors++; $display("FAIL hold_quotient_during_run: got %h want 64", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL hold_remainder_during_run: got %h want 0", remainder); end
    wait_ready(40, lat, q, r, e);
    x = sbq.pop_front();
    checks++; if (lat != 28) begin errors++; $display("FAIL hold_latency: got %0d want 28", lat); end
    checks++; if (q !== x.q) begin errors++; $display("FAIL hold_quotient: got %h want %h", q, x.q); end
    checks++; if (r !== x.r) begin errors++; $display("FAIL hold_remainder: got %h want %h", r, x.r); end
  endtask

  task automatic test_restart;
    int lat; int spurious; logic [31:0] q, r; logic e; exp_t x;
    spurious = 0;
    do_start(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
    x = sbq.pop_back();
    repeat (8) begin
      @(negedge clock);
      if (ready === 1'b1) spurious++;
    end
    do_start(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    wait_ready(45, lat, q, r, e);
    x = sbq.pop_front();
    checks++; if (spurious != 0) begin errors++; $display("FAIL restart_spurious_ready: got %0d want 0", spurious); end
    checks++; if (lat != 33) begin errors++; $display("FAIL restart_latency: got %0d want 33", lat); end
    checks++; if (q !== x.q) begin errors++; $display("FAIL restart_quotient: got %h want %h", q, x.q); end
    checks++; if (r !== x.r) begin errors++; $display("FAIL restart_remainder: got %h want %h", r, x.r); end
    @(negedge clock);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL restart_single_ready: got %b want 0", ready); end
  endtask

  task automatic test_reset_abort;
    int lat; logic [31:0] q, r; logic e; exp_t x;
    do_start(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    x = sbq.pop_back();
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    wait_ready(40, lat, q, r, e);
    checks++; if (lat != -1) begin errors++; $display("FAIL abort_ready_seen: got latency %0d want none", lat); end
    checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL abort_quotient: got %h want 0", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL abort_remainder: got %h want 0", remainder); end
    checks++; if (exception !== 1'b0) begin errors++; $display("FAIL abort_exception: got %b want 0", exception); end
  endtask

  // Each new start is driven in the DONE cycle of the previous operation.
  task automatic test_back_to_back;
    int lat; logic [31:0] q, r; logic e; exp_t x; exp_t m;
    logic [31:0] a, b;
    a = $urandom; b = $urandom_range(1, 1000);
    m = model(a, b);
    do_start(a, b, m.q, m.r, m.e);
    for (int i = 0; i < 8; i++) begin
      wait_ready(40, lat, q, r, e);
      x = sbq.pop_front();
      checks++; if (lat != 33) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want 33", i, lat); end
      checks++; if (q !== x.q) begin errors++; $display("FAIL b2b_quotient[%0d]: got %h want %h", i, q, x.q); end
      checks++; if (r !== x.r) begin errors++; $display("FAIL b2b_remainder[%0d]: got %h want %h", i, r, x.r); end
      checks++; if (e !== x.e) begin errors++; $display("FAIL b2b_exception[%0d]: got %b want %b", i, e, x.e); end
      if (i < 7) begin
        a = $urandom;
        case (i % 4)
          0: b = $urandom;
          1: b = -$urandom_range(1, 50);
          2: b = $urandom_range(1, 50);
          default: b = (i == 3) ? 32'd0 : $urandom;
        endcase
        m = model(a, b);
        launch(a, b, m.q, m.r, m.e);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_exceptions();
    test_hold();
    test_restart();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
